mdu_seq: RTL and testbench



---
 rtl/mdu_seq_if.sv | 23 ++
 rtl/mdu_seq.sv | 138 +++++++++++++
 tb/tb_mdu_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_if.sv
// rtl/mdu_seq_if.sv - E-stage to multiply/divide sequencer interface (start, operands, MFHI/MFLO, stall, HI/LO)
interface mdu_seq_if;
    logic        StartE;
    logic [1:0]  OpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        MfHiE;
    logic        MfLoE;
    logic        StallMD;
    logic        Busy;
    logic [31:0] HiOut;
    logic [31:0] LoOut;

    modport master (
        output StartE, OpE, SrcAE, SrcBE, MfHiE, MfLoE,
        input  StallMD, Busy, HiOut, LoOut
    );

    modport slave (
        input  StartE, OpE, SrcAE, SrcBE, MfHiE, MfLoE,
        output StallMD, Busy, HiOut, LoOut
    );
endinterface

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with E-stage stall request
// Optional MDU_EARLY_OUT_EN: multiply leaves ITER as soon as the remaining multiplier is zero.
module mdu_seq #(
    parameter int N_ITER = 32
) (
    input  logic     clk,
    input  logic     reset,
    mdu_seq_if.slave md
);
    localparam int CW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N_ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    logic        isDiv;
    logic        signA;
    logic        signB;
    logic [31:0] aCap;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic [CW-1:0] cnt;
    logic [31:0] hiReg;
    logic [31:0] loReg;

    logic        startSignA;
    logic        startSignB;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [32:0] trial;
    logic        trialGe;
    logic [31:0] remNext;
    logic [31:0] fixHi;
    logic [31:0] fixLo;
    logic        earlyOut;
    logic        lastIter;

    // OpE[1] selects divide, OpE[0] selects signed
    always_comb begin
        startSignA = md.OpE[0] & md.SrcAE[31];
        startSignB = md.OpE[0] & md.SrcBE[31];
        absA = startSignA ? (~md.SrcAE + 32'd1) : md.SrcAE;
        absB = startSignB ? (~md.SrcBE + 32'd1) : md.SrcBE;
    end

    // Restoring divide step: acc holds {rem, quo}; dividend bits stream out of mcand[31]
    always_comb begin
        trial   = {acc[63:32], mcand[31]};
        trialGe = (trial >= {1'b0, mplier});
        remNext = trialGe ? (trial[31:0] - mplier) : trial[31:0];
    end

`ifdef MDU_EARLY_OUT_EN
    assign earlyOut = !isDiv && (mplier == 32'd0);
`else
    assign earlyOut = 1'b0;
`endif

    assign lastIter = (cnt == LAST_CNT) || earlyOut;

    always_comb begin
        fixHi = 32'd0;
        fixLo = 32'd0;
        if (!isDiv) begin
            {fixHi, fixLo} = (signA ^ signB) ? (~acc + 64'd1) : acc;
        end else if (mplier == 32'd0) begin
            fixHi = aCap;
            fixLo = 32'hFFFF_FFFF;
        end else begin
            fixLo = (signA ^ signB) ? (~acc[31:0] + 32'd1) : acc[31:0];
            fixHi = signA ? (~acc[63:32] + 32'd1) : acc[63:32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            isDiv  <= 1'b0;
            signA  <= 1'b0;
            signB  <= 1'b0;
            aCap   <= 32'd0;
            mcand  <= 64'd0;
            mplier <= 32'd0;
            acc    <= 64'd0;
            cnt    <= '0;
            hiReg  <= 32'd0;
            loReg  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (md.StartE) begin
                        isDiv  <= md.OpE[1];
                        signA  <= startSignA;
                        signB  <= startSignB;
                        aCap   <= md.SrcAE;
                        mcand  <= {32'd0, absA};
                        mplier <= absB;
                        acc    <= 64'd0;
                        cnt    <= '0;
                        state  <= ITER;
                    end
                end
                ITER: begin
                    if (!isDiv) begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        acc   <= {remNext, acc[30:0], trialGe};
                        mcand <= mcand << 1;
                    end
                    cnt <= cnt + 1'b1;
                    if (lastIter) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hiReg <= fixHi;
                    loReg <= fixLo;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign md.Busy    = (state != IDLE);
    assign md.StallMD = (state != IDLE) & (md.StartE | md.MfHiE | md.MfLoE);
    assign md.HiOut   = hiReg;
    assign md.LoOut   = loReg;
endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - directed-vector self-checking bench for mdu_seq
module tb_mdu_seq;
    logic clk = 1'b0;
    logic reset;
    int   nVec = 0;
    int   nErr = 0;

`ifdef MDU_EARLY_OUT_EN
    localparam int BUSY_B6  = 5;
    localparam int BUSY_B16 = 7;
`else
    localparam int BUSY_B6  = 33;
    localparam int BUSY_B16 = 33;
`endif

    mdu_seq_if mdIf ();

    mdu_seq #(.N_ITER(32)) dut (
        .clk  (clk),
        .reset(reset),
        .md   (mdIf)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busyLen);
        @(negedge clk);
        mdIf.OpE    = op;
        mdIf.SrcAE  = a;
        mdIf.SrcBE  = b;
        mdIf.StartE = 1'b1;
        @(posedge clk);
        #1;
        mdIf.StartE = 1'b0;
        busyLen = 0;
        while (mdIf.Busy && busyLen < 200) begin
            @(posedge clk);
            #1;
            busyLen++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mdIf.StartE = 1'b0;
        mdIf.OpE    = 2'b00;
        mdIf.SrcAE  = 32'd0;
        mdIf.SrcBE  = 32'd0;
        mdIf.MfHiE  = 1'b1;
        mdIf.MfLoE  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nVec++; if (mdIf.Busy !== 1'b0) begin nErr++; $display("FAIL reset_busy: got %b expected 0", mdIf.Busy); end
        nVec++; if (mdIf.StallMD !== 1'b0) begin nErr++; $display("FAIL reset_stall: got %b expected 0", mdIf.StallMD); end
        nVec++; if (mdIf.HiOut !== 32'd0) begin nErr++; $display("FAIL reset_hi: got %h expected 00000000", mdIf.HiOut); end
        nVec++; if (mdIf.LoOut !== 32'd0) begin nErr++; $display("FAIL reset_lo: got %h expected 00000000", mdIf.LoOut); end
        @(negedge clk);
        mdIf.MfHiE = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_multu();
        int n;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        nVec++; if (n !== 33) begin nErr++; $display("FAIL multu_busy: got %0d expected 33", n); end
        nVec++; if (mdIf.HiOut !== 32'hFFFF_FFFE) begin nErr++; $display("FAIL multu_hi: got %h expected fffffffe", mdIf.HiOut); end
        nVec++; if (mdIf.LoOut !== 32'h0000_0001) begin nErr++; $display("FAIL multu_lo: got %h expected 00000001", mdIf.LoOut); end
        run_op(2'b00, 32'h1234_5678, 32'h0000_0010, n);
        nVec++; if (mdIf.HiOut !== 32'h0000_0001) begin nErr++; $display("FAIL multu16_hi: got %h expected 00000001", mdIf.HiOut); end
        nVec++; if (mdIf.LoOut !== 32'h2345_6780) begin nErr++; $display("FAIL multu16_lo: got %h expected 23456780", mdIf.LoOut); end
    endtask

    task automatic test_mult();
        int n;
        run_op(2'b01, 32'hFFFF_FFF9, 32'd6, n);
        nVec++; if (n !== BUSY_B6) begin nErr++; $display("FAIL mult_busy: got %0d expected %0d", n, BUSY_B6); end
        nVec++; if (mdIf.HiOut !== 32'hFFFF_FFFF) begin nErr++; $display("FAIL mult_hi: got %h expected ffffffff", mdIf.HiOut); end
        nVec++; if (mdIf.LoOut !== 32'hFFFF_FFD6) begin nErr++; $display("FAIL mult_lo: got %h expected ffffffd6", mdIf.LoOut); end
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, n);
        nVec++; if (mdIf.HiOut !== 32'h4000_0000) begin nErr++; $display("FAIL mult_min_hi: got %h expected 40000000", mdIf.HiOut); end
        nVec++; if (mdIf.LoOut !== 32'h0000_0000) begin nErr++; $display("FAIL mult_min_lo: got %h expected 00000000", mdIf.LoOut); end
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        nVec++; if (mdIf.HiOut !== 32'h0000_0000) begin nErr++; $display("FAIL mult_m1_hi: got %h expected 00000000", mdIf.HiOut); end
        nVec++; if (mdIf.LoOut !== 32'h0000_0001) begin nErr++; $display("FAIL mult_m1_lo: got %h expected 00000001", mdIf.LoOut); end
    endtask

    task automatic test_div();
        int n;
        run_op(2'b11, 32'hFFFF_FFEF, 32'd5, n);
        nVec++; if (n !== 33) begin nErr++; $display("FAIL div_busy: got %0d expected 33", n); end
        nVec++; if (mdIf.LoOut !== 32'hFFFF_FFFD) begin nErr++; $display("FAIL div_lo: got %h expected fffffffd", mdIf.LoOut); end
        nVec++; if (mdIf.HiOut !== 32'hFFFF_FFFE) begin nErr++; $display("FAIL div_hi: got %h expected fffffffe", mdIf.HiOut); end
        run_op(2'b11, 32'd17, 32'hFFFF_FFFB, n);
        nVec++; if (mdIf.LoOut !== 32'hFFFF_FFFD) begin nErr++; $display("FAIL div_negb_lo: got %h expected fffffffd", mdIf.LoOut); end
        nVec++; if (mdIf.HiOut !== 32'h0000_0002) begin nErr++; $display("FAIL div_negb_hi: got %h expected 00000002", mdIf.HiOut); end
        run_op(2'b10, 32'd100, 32'd7, n);
        nVec++; if (mdIf.LoOut !== 32'd14) begin nErr++; $display("FAIL divu_lo: got %h expected 0000000e", mdIf.LoOut); end
        nVec++; if (mdIf.HiOut !== 32'd2) begin nErr++; $display("FAIL divu_hi: got %h expected 00000002", mdIf.HiOut); end
        run_op(2'b10, 32'hFFFF_FFFF, 32'd1, n);
        nVec++; if (mdIf.LoOut !== 32'hFFFF_FFFF) begin nErr++; $display("FAIL divu_max_lo: got %h expected ffffffff", mdIf.LoOut); end
        nVec++; if (mdIf.HiOut !== 32'd0) begin nErr++; $display("FAIL divu_max_hi: got %h expected 00000000", mdIf.HiOut); end
    endtask

    task automatic test_div_zero();
        int n;
        run_op(2'b10, 32'd100, 32'd0, n);
        nVec++; if (mdIf.HiOut !== 32'd100) begin nErr++; $display("FAIL divu0_hi: got %h expected 00000064", mdIf.HiOut); end
        nVec++; if (mdIf.LoOut !== 32'hFFFF_FFFF) begin nErr++; $display("FAIL divu0_lo: got %h expected ffffffff", mdIf.LoOut); end
        run_op(2'b11, 32'hFFFF_FFF7, 32'd0, n);
        nVec++; if (mdIf.HiOut !== 32'hFFFF_FFF7) begin nErr++; $display("FAIL div0_hi: got %h expected fffffff7", mdIf.HiOut); end
        nVec++; if (mdIf.LoOut !== 32'hFFFF_FFFF) begin nErr++; $display("FAIL div0_lo: got %h expected ffffffff", mdIf.LoOut); end
    endtask

    task automatic test_mflo_stall();
        int n;
        @(negedge clk);
        mdIf.OpE    = 2'b01;
        mdIf.SrcAE  = 32'd123;
        mdIf.SrcBE  = 32'd6;
        mdIf.StartE = 1'b1;
        @(posedge clk);
        #1;
        mdIf.StartE = 1'b0;
        @(posedge clk);
        #1;
        mdIf.MfLoE = 1'b1;
        #1;
        nVec++; if (mdIf.StallMD !== 1'b1) begin nErr++; $display("FAIL mflo_stall_on: got %b expected 1", mdIf.StallMD); end
        n = 0;
        while (mdIf.StallMD && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        nVec++; if (n !== BUSY_B6 - 1) begin nErr++; $display("FAIL mflo_stall_len: got %0d expected %0d", n, BUSY_B6 - 1); end
        nVec++; if (mdIf.LoOut !== 32'h0000_02E2) begin nErr++; $display("FAIL mflo_lo: got %h expected 000002e2", mdIf.LoOut); end
        nVec++; if (mdIf.Busy !== 1'b0) begin nErr++; $display("FAIL mflo_busy: got %b expected 0", mdIf.Busy); end
        mdIf.MfLoE = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        mdIf.OpE    = 2'b10;
        mdIf.SrcAE  = 32'd100;
        mdIf.SrcBE  = 32'd7;
        mdIf.StartE = 1'b1;
        @(posedge clk);
        #1;
        mdIf.OpE   = 2'b00;
        mdIf.SrcAE = 32'd3;
        mdIf.SrcBE = 32'd5;
        nVec++; if (mdIf.StallMD !== 1'b1) begin nErr++; $display("FAIL b2b_stall_on: got %b expected 1", mdIf.StallMD); end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (mdIf.StallMD && n < 200);
        nVec++; if (n !== 33) begin nErr++; $display("FAIL b2b_release: got %0d expected 33", n); end
        nVec++; if (mdIf.LoOut !== 32'd14) begin nErr++; $display("FAIL b2b_first_lo: got %h expected 0000000e", mdIf.LoOut); end
        nVec++; if (mdIf.HiOut !== 32'd2) begin nErr++; $display("FAIL b2b_first_hi: got %h expected 00000002", mdIf.HiOut); end
        @(posedge clk);
        #1;
        mdIf.StartE = 1'b0;
        nVec++; if (mdIf.Busy !== 1'b1) begin nErr++; $display("FAIL b2b_second_accept: got %b expected 1", mdIf.Busy); end
        n = 0;
        while (mdIf.Busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        nVec++; if (mdIf.LoOut !== 32'd15) begin nErr++; $display("FAIL b2b_second_lo: got %h expected 0000000f", mdIf.LoOut); end
        nVec++; if (mdIf.HiOut !== 32'd0) begin nErr++; $display("FAIL b2b_second_hi: got %h expected 00000000", mdIf.HiOut); end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        mdIf.OpE    = 2'b10;
        mdIf.SrcAE  = 32'd100;
        mdIf.SrcBE  = 32'd7;
        mdIf.StartE = 1'b1;
        @(posedge clk);
        #1;
        mdIf.StartE = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        nVec++; if (mdIf.Busy !== 1'b0) begin nErr++; $display("FAIL rstmid_busy: got %b expected 0", mdIf.Busy); end
        nVec++; if (mdIf.HiOut !== 32'd0) begin nErr++; $display("FAIL rstmid_hi: got %h expected 00000000", mdIf.HiOut); end
        nVec++; if (mdIf.LoOut !== 32'd0) begin nErr++; $display("FAIL rstmid_lo: got %h expected 00000000", mdIf.LoOut); end
        @(negedge clk);
        reset = 1'b0;
        run_op(2'b00, 32'h1234_5678, 32'h0000_0010, n);
        nVec++; if (n !== BUSY_B16) begin nErr++; $display("FAIL rstmid_after_busy: got %0d expected %0d", n, BUSY_B16); end
        nVec++; if (mdIf.HiOut !== 32'h0000_0001) begin nErr++; $display("FAIL rstmid_after_hi: got %h expected 00000001", mdIf.HiOut); end
        nVec++; if (mdIf.LoOut !== 32'h2345_6780) begin nErr++; $display("FAIL rstmid_after_lo: got %h expected 23456780", mdIf.LoOut); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_mflo_stall();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
